// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: inst and data caches share one AR/R channel, one read in flight.
// Define ARB_RR_EN for round-robin grant; otherwise the data cache has fixed priority.
module axi_rd_arbiter #(
   parameter int unsigned LINE_WORDS = 8,
   parameter logic [3:0]  INST_ID    = 4'd0,
   parameter logic [3:0]  DATA_ID    = 4'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_rd_req,
   input  logic        inst_rd_type,
   input  logic [31:0] inst_rd_addr,
   output logic        inst_rd_rdy,
   output logic        inst_ret_valid,
   output logic        inst_ret_last,
   output logic [31:0] inst_ret_data,
   input  logic        data_rd_req,
   input  logic        data_rd_type,
   input  logic [31:0] data_rd_addr,
   output logic        data_rd_rdy,
   output logic        data_ret_valid,
   output logic        data_ret_last,
   output logic [31:0] data_ret_data,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        prot_err
);

   localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t      state, state_nxt;
   logic        owner_data;   // 1 = data cache owns the channel
   logic [31:0] addr_q;
   logic        type_q;
   logic        grant_inst, grant_data, accept;
   logic [3:0]  owner_id;
   logic        beat, id_match;

`ifdef ARB_RR_EN
   logic last_owner_data;

   // On a tie the requester that did not win last time takes the channel.
   always_comb begin
      grant_data = data_rd_req & (~inst_rd_req | ~last_owner_data);
      grant_inst = inst_rd_req & (~data_rd_req | last_owner_data);
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_owner_data <= 1'b0;
      else if (accept)
         last_owner_data <= grant_data;
   end
`else
   assign grant_data = data_rd_req;
   assign grant_inst = inst_rd_req & ~data_rd_req;
`endif

   // rdy is held low during reset so nothing is captured while the FSM is being cleared.
   assign inst_rd_rdy = (state == S_IDLE) & ~reset & grant_inst;
   assign data_rd_rdy = (state == S_IDLE) & ~reset & grant_data;
   assign accept      = inst_rd_rdy | data_rd_rdy;

   assign owner_id = owner_data ? DATA_ID : INST_ID;
   assign beat     = (state == S_DATA) & rvalid;
   assign id_match = (rid == owner_id);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         owner_data <= 1'b0;
         addr_q     <= '0;
         type_q     <= 1'b0;
         prot_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner_data <= grant_data;
            addr_q     <= grant_data ? data_rd_addr : inst_rd_addr;
            type_q     <= grant_data ? data_rd_type : inst_rd_type;
         end
         if (beat & ~id_match)
            prot_err <= 1'b1;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      arvalid   = 1'b0;
      rready    = 1'b0;
      unique case (state)
         S_IDLE: if (accept) state_nxt = S_ADDR;
         S_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = S_DATA;
         end
         S_DATA: begin
            rready = 1'b1;
            if (rvalid & rlast & id_match) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Line refills start at the line boundary; uncached reads use the exact word address.
   assign arid    = owner_id;
   assign arlen   = type_q ? 8'(LINE_WORDS - 1) : 8'd0;
   assign araddr  = type_q ? (addr_q & ~LINE_MASK) : addr_q;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;

   // Beats carrying a foreign rid are swallowed here and never reach either cache.
   assign inst_ret_valid = beat & id_match & ~owner_data;
   assign data_ret_valid = beat & id_match & owner_data;
   assign inst_ret_last  = rlast;
   assign data_ret_last  = rlast;
   assign inst_ret_data  = rdata;
   assign data_ret_data  = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter: a protocol-level model predicts grants,
// AR fields and routed beats; a monitor compares them against the DUT every falling edge.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

   localparam int LW = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_rd_req, inst_rd_type, inst_rd_rdy, inst_ret_valid, inst_ret_last;
   logic [31:0] inst_rd_addr, inst_ret_data;
   logic        data_rd_req, data_rd_type, data_rd_rdy, data_ret_valid, data_ret_last;
   logic [31:0] data_rd_addr, data_ret_data;
   logic [3:0]  arid, rid;
   logic [31:0] araddr, rdata;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready, rlast, rvalid, rready, prot_err;

   axi_rd_arbiter #(.LINE_WORDS(LW), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
      .clk(clk), .reset(reset),
      .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
      .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
      .inst_ret_data(inst_ret_data),
      .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
      .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
      .data_ret_data(data_ret_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .prot_err(prot_err)
   );

   always #5 clk = ~clk;

   typedef enum {P_IDLE, P_ADDR, P_DATA} phase_t;
   typedef struct {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} ar_exp_t;
   typedef struct {bit good; logic [31:0] data; bit last;} ret_exp_t;

   ar_exp_t  ar_q[$];
   ret_exp_t ret_q[$];
   phase_t   phase = P_IDLE;
   bit       owner = 1'b0;        // 1 = data cache owns the outstanding read
   bit       last_owner = 1'b0;
   bit       model_prot = 1'b0;
   int       n_tests = 0, n_fail = 0;

   bit          slave_stall = 0, slave_busy = 0, force_bad = 0, allow_bad = 0, allow_early = 0;
   bit          use_fixed = 0;
   logic [31:0] fixed_data = 32'h0;
   int          force_wait = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
   endtask

   // ---------------- monitor / reference model ----------------
   task automatic monitor_cycle();
      phase_t      ph;
      bit          g_i, g_d;
      logic        typ;
      logic [31:0] a;
      ar_exp_t     ar;
      ret_exp_t    e;
      ph  = phase;
      g_i = 1'b0;
      g_d = 1'b0;
      check("prot_err", prot_err, model_prot);
      check("arvalid", arvalid, ph == P_ADDR);
      check("rready", rready, ph == P_DATA);

      if (ph == P_IDLE) begin
`ifdef ARB_RR_EN
         if (inst_rd_req && data_rd_req) begin
            g_d = !last_owner;
            g_i = last_owner;
         end else begin
            g_d = data_rd_req;
            g_i = inst_rd_req;
         end
`else
         g_d = data_rd_req;
         g_i = inst_rd_req && !data_rd_req;
`endif
      end
      check("inst_rd_rdy", inst_rd_rdy, g_i);
      check("data_rd_rdy", data_rd_rdy, g_d);

      if (ph == P_ADDR) begin
         if (ar_q.size() == 0) fail_now("ar_unexpected");
         else begin
            check("arid", arid, ar_q[0].id);
            check("araddr", araddr, ar_q[0].addr);
            check("arlen", arlen, ar_q[0].len);
            check("arsize", arsize, 3'b010);
            check("arburst", arburst, 2'b01);
            if (arready) begin
               void'(ar_q.pop_front());
               phase = P_DATA;
            end
         end
      end

      if (ph == P_DATA && rvalid) begin
         if (ret_q.size() == 0) fail_now("ret_unexpected");
         else begin
            e = ret_q.pop_front();
            check("inst_ret_valid", inst_ret_valid, e.good && !owner);
            check("data_ret_valid", data_ret_valid, e.good && owner);
            if (e.good) begin
               if (owner) begin
                  check("data_ret_data", data_ret_data, e.data);
                  check("data_ret_last", data_ret_last, e.last);
               end else begin
                  check("inst_ret_data", inst_ret_data, e.data);
                  check("inst_ret_last", inst_ret_last, e.last);
               end
               if (e.last) phase = P_IDLE;
            end else begin
               model_prot = 1'b1;
            end
         end
      end else begin
         check("inst_ret_quiet", inst_ret_valid, 1'b0);
         check("data_ret_quiet", data_ret_valid, 1'b0);
      end

      if (g_i || g_d) begin
         owner      = g_d;
         last_owner = g_d;
         typ        = g_d ? data_rd_type : inst_rd_type;
         a          = g_d ? data_rd_addr : inst_rd_addr;
         ar.id      = g_d ? 4'd1 : 4'd0;
         ar.len     = typ ? 8'(LW - 1) : 8'd0;
         ar.addr    = typ ? a - (a % (LW * 4)) : a;
         ar_q.push_back(ar);
         phase = P_ADDR;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rdy_in_reset", {30'd0, inst_rd_rdy, data_rd_rdy}, 32'd0);
            phase      = P_IDLE;
            model_prot = 1'b0;
            last_owner = 1'b0;
            ar_q.delete();
            ret_q.delete();
         end else begin
            monitor_cycle();
         end
      end
   end

   // ---------------- AXI slave ----------------
   task automatic push_beat(input logic [3:0] id, input bit good, input bit last);
      ret_exp_t e;
      rvalid = 1'b1;
      rid    = id;
      rdata  = use_fixed ? fixed_data : $urandom;
      rlast  = last;
      e.good = good;
      e.data = rdata;
      e.last = last;
      ret_q.push_back(e);
   endtask

   task automatic slave_txn();
      int         w, len;
      logic [3:0] id;
      bit         done, last;
      slave_busy = 1;
      done = 0;
      w = (force_wait >= 0) ? force_wait : $urandom_range(0, 2);
      force_wait = -1;
      for (int i = 0; i < w; i++) begin
         @(posedge clk); #1;
         if (reset) begin slave_busy = 0; return; end
      end
      arready = 1'b1;
      id  = arid;
      len = int'(arlen);
      @(posedge clk); #1;
      arready = 1'b0;
      if (reset) begin slave_busy = 0; return; end
      for (int i = 0; i <= len && !done; i++) begin
         while (slave_stall || $urandom_range(0, 3) == 0) begin
            rvalid = 1'b0;
            @(posedge clk); #1;
            if (reset) begin slave_busy = 0; return; end
         end
         if ((force_bad && i == 2) || (allow_bad && $urandom_range(0, 15) == 0)) begin
            force_bad = 0;
            push_beat(4'd3, 1'b0, 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            if (reset) begin rvalid = 1'b0; slave_busy = 0; return; end
         end
         last = (i == len) || (allow_early && $urandom_range(0, 11) == 0);
         push_beat(id, 1'b1, last);
         done = last;
         @(posedge clk); #1;
         if (reset) begin rvalid = 1'b0; slave_busy = 0; return; end
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      slave_busy = 0;
   endtask

   initial begin
      arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rlast = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!reset && arvalid) slave_txn();
      end
   end

   // ---------------- requesters ----------------
   task automatic raise(input bit d, input bit t, input logic [31:0] a);
      if (d) begin data_rd_req = 1'b1; data_rd_type = t; data_rd_addr = a; end
      else   begin inst_rd_req = 1'b1; inst_rd_type = t; inst_rd_addr = a; end
   endtask

   task automatic step(output bit ai, output bit ad);
      @(negedge clk);
      ai = inst_rd_rdy;
      ad = data_rd_rdy;
      @(posedge clk); #1;
      if (ai) inst_rd_req = 1'b0;
      if (ad) data_rd_req = 1'b0;
   endtask

   task automatic wait_quiet(input string name);
      bit ai, ad;
      for (int i = 0; i < 400; i++) begin
         if (!inst_rd_req && !data_rd_req && phase == P_IDLE && ar_q.size() == 0 &&
             ret_q.size() == 0 && !slave_busy)
            return;
         step(ai, ad);
      end
      fail_now(name);
   endtask

   function automatic logic [31:0] rand_addr();
      return $urandom & 32'hFFFF_FFFC;
   endfunction

   initial begin
      bit ai, ad;
      int grants;
      reset = 1'b1;
      inst_rd_req = 0; inst_rd_type = 0; inst_rd_addr = 0;
      data_rd_req = 0; data_rd_type = 0; data_rd_addr = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) step(ai, ad);

      raise(0, 1, 32'h1FC0_0014);
      wait_quiet("inst_line_done");

      use_fixed = 1; fixed_data = 32'hDEAD_BEEF;
      raise(1, 0, 32'h1FAF_F004);
      wait_quiet("data_word_done");
      use_fixed = 0;

      raise(0, 1, rand_addr());
      raise(1, 1, rand_addr());
      wait_quiet("simultaneous_done");

      force_wait = 5;
      raise(0, 1, rand_addr());
      step(ai, ad);
      raise(1, 0, rand_addr());
      wait_quiet("ar_stall_done");

      force_bad = 1;
      raise(0, 1, rand_addr());
      wait_quiet("bad_rid_done");

      grants = 0;
      raise(0, 1, rand_addr());
      raise(1, 1, rand_addr());
      for (int i = 0; i < 300 && (inst_rd_req || data_rd_req); i++) begin
         step(ai, ad);
         grants += int'(ai) + int'(ad);
         if (grants < 4) begin
            if (ai) raise(0, 1'($urandom_range(0, 1)), rand_addr());
            if (ad) raise(1, 1'($urandom_range(0, 1)), rand_addr());
         end
      end
      wait_quiet("four_grants_done");

      allow_bad = 1; allow_early = 1;
      for (int c = 0; c < 500; c++) begin
         step(ai, ad);
         if (!inst_rd_req && $urandom_range(0, 2) == 0) raise(0, 1'($urandom_range(0, 1)), rand_addr());
         if (!data_rd_req && $urandom_range(0, 2) == 0) raise(1, 1'($urandom_range(0, 1)), rand_addr());
      end
      wait_quiet("random_done");
      allow_bad = 0; allow_early = 0;

      force_bad = 1;
      raise(1, 1, rand_addr());
      wait_quiet("prot_set_done");
      slave_stall = 1;
      raise(0, 1, rand_addr());
      for (int i = 0; i < 50 && phase != P_DATA; i++) step(ai, ad);
      if (phase != P_DATA) fail_now("reach_data_phase");
      repeat (2) step(ai, ad);
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      slave_stall = 0;
      repeat (3) step(ai, ad);
      raise(1, 1, rand_addr());
      wait_quiet("post_reset_done");

      check("ar_q_drained", ar_q.size(), 0);
      check("ret_q_drained", ret_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel between the inst cache and the data cache.
- Grants one requester at a time, issues the AR transaction, then routes R beats back to the owner.
- Sits between the two caches and the AXI bridge.
- One outstanding read only: the grant is held until the owner's RLAST beat is accepted.

Parameters:
LINE_WORDS, 8, words per cache-line refill burst; arlen = LINE_WORDS-1; power of two, max 16
INST_ID, 4'd0, ARID used for inst cache transactions
DATA_ID, 4'd1, ARID used for data cache transactions

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_rd_req  in  1  inst cache read request
inst_rd_type  in  1  1 = line burst, 0 = single word (uncached)
inst_rd_addr  in  32  physical address
inst_rd_rdy  out  1  request accepted this cycle
inst_ret_valid  out  1  return beat valid
inst_ret_last  out  1  final beat
inst_ret_data  out  32  return data
data_rd_req  in  1  data cache read request
data_rd_type  in  1  as inst_rd_type
data_rd_addr  in  32  as inst_rd_addr
data_rd_rdy  out  1  as inst_rd_rdy
data_ret_valid  out  1  as inst_ret_valid
data_ret_last  out  1  as inst_ret_last
data_ret_data  out  32  as inst_ret_data
arid  out  4  AXI read ID
araddr  out  32  AXI read address
arlen  out  8  burst length - 1
arsize  out  3  fixed 3'b010
arburst  out  2  fixed 2'b01 (INCR)
arvalid  out  1  address valid
arready  in  1  slave address ready
rid  in  4  read data ID
rdata  in  32  read data
rlast  in  1  last beat
rvalid  in  1  read data valid
rready  out  1  master ready
prot_err  out  1  sticky: beat with unexpected rid

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- FSM states:
  - IDLE: arvalid=0, rready=0.
  - ADDR: arvalid=1; moves to DATA on arvalid&arready.
  - DATA: rready=1; moves to IDLE on rvalid&rlast&(rid==owner ID).
- Grant and capture:
  - In IDLE, x_rd_rdy = x_rd_req & grant_x; rdy is combinational.
  - Grant (fixed priority): data over inst.
  - On an accepting cycle: capture owner, address, type; go to ADDR the next cycle. Request-to-arvalid latency is 1 cycle.
  - rdy is 0 in ADDR and DATA.
- AR fields (from registers, stable while arvalid=1):
  - arid = owner ID.
  - arlen = type ? LINE_WORDS-1 : 0.
  - araddr = type ? {addr[31:log2(LINE_WORDS)+2], zeros} : addr.
- Return path:
  - owner_ret_valid = (state==DATA) & rvalid & (rid==owner ID).
  - ret_last = rlast; ret_data = rdata.
  - Non-owner ret_valid stays 0.
  - Returns are combinational pass-through, zero added latency.
- rid mismatch in DATA: beat consumed (rready=1), dropped, prot_err set; state unchanged. prot_err clears only on reset.
- A burst ending early on rlast is accepted as complete. No beat counting except in the optional feature.
- Back-to-back: the cycle after the last beat, state is IDLE and a new grant is possible. Minimum 3 cycles between grants (IDLE→ADDR→DATA).
- Both requests asserted in IDLE: exactly one rdy is high.
- Request inputs are ignored outside IDLE; requesters hold req until rdy.
- Reset (including mid-transaction): state=IDLE, arvalid=0, rready=0, both rdy=0, both ret_valid=0, prot_err=0, owner/addr/type registers cleared. The downstream bridge is reset together with this block.

Optional Feature:
- ARB_RR_EN defined:
  - Round-robin grant: a 1-bit last_owner register (reset = inst).
  - When both request, grant goes to the requester that was not last_owner.
  - last_owner is updated on each grant.
- ARB_RR_EN undefined: fixed data-over-inst priority; no last_owner register.

Test Plan:
- Single inst line: inst_rd_req=1, type=1, addr=0x1FC0_0014 → araddr=0x1FC0_0000, arlen=7, arid=0; 8 beats with rid=0 → 8 inst_ret_valid pulses, last with ret_last; FSM back to IDLE.
- Uncached data word: data_rd_req, type=0, addr=0x1FAF_F004 → araddr=0x1FAF_F004, arlen=0, arid=1; one beat 0xDEADBEEF → data_ret_data=0xDEADBEEF with last.
- Simultaneous requests, fixed priority: both req in the same cycle → data_rd_rdy=1, inst_rd_rdy=0. After data's rlast, inst is granted on the next IDLE cycle.
- Same with ARB_RR_EN and both held high for 4 grants → owners alternate data, inst, data, inst.
- arready held low 5 cycles → arvalid stays high and araddr/arlen/arid stay stable; no rdy asserted meanwhile.
- rid=3 beat mid-burst → no ret_valid on either port, prot_err=1 and stays 1. Reset asserted during DATA → next cycle IDLE, arvalid=0, rready=0, prot_err=0.
